// File: rtl/iic_arbiter.sv
// rtl/iic_arbiter.sv - round-robin arbiter sequencing NREQ clients onto one iic_master
module iic_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 2000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*7-1:0] req_dev_addr,
  input  logic [NREQ*8-1:0] req_reg_addr,
  input  logic [NREQ-1:0]   req_w,
  input  logic [NREQ*8-1:0] req_wd,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rdata,
  output logic              err,
  output logic              m_start,
  output logic [6:0]        m_dev_addr,
  output logic [7:0]        m_reg_addr,
  output logic              m_w,
  output logic [7:0]        m_wd,
  input  logic [7:0]        m_rdata,
  input  logic              m_done
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  ptr, owner, win;
  logic           win_vld;
  logic [CW-1:0]  cnt;
  logic           take_grant, take_done, take_timeout;

  // Scan starts just past the last served client so every requester gets a turn.
  always_comb begin : pick
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!win_vld && req[idx]) begin
        win     = PW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    take_grant   = 1'b0;
    take_done    = 1'b0;
    take_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (en && win_vld) begin
          take_grant = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (m_done) begin
          take_done = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          take_timeout = 1'b1;
          state_nxt    = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt        <= '0;
      ack        <= '0;
      err        <= 1'b0;
      m_start    <= 1'b0;
      rdata      <= '0;
      m_dev_addr <= '0;
      m_reg_addr <= '0;
      m_w        <= 1'b0;
      m_wd       <= '0;
      ptr        <= PW'(NREQ - 1);
      owner      <= '0;
      cnt        <= '0;
    end else begin
      gnt     <= '0;
      ack     <= '0;
      err     <= 1'b0;
      m_start <= 1'b0;
      if (take_grant) begin
        m_dev_addr <= req_dev_addr[int'(win)*7 +: 7];
        m_reg_addr <= req_reg_addr[int'(win)*8 +: 8];
        m_w        <= req_w[win];
        m_wd       <= req_wd[int'(win)*8 +: 8];
        owner      <= win;
        gnt[win]   <= 1'b1;
        m_start    <= 1'b1;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CW'(1);
      // rdata is captured on writes too; a timeout leaves it untouched.
      if (take_done) begin
        rdata      <= m_rdata;
        ack[owner] <= 1'b1;
        ptr        <= owner;
      end
      if (take_timeout) begin
        ack[owner] <= 1'b1;
        err        <= 1'b1;
        ptr        <= owner;
      end
    end
  end

endmodule
